alu_vector_player: RTL and testbench

Synthesizable self-test sequencer that sits directly upstream and downstream of the ALU. It fetches 100-bit test vectors from a synchronous vector ROM, drives the ALU operands and opcode, waits for settling, and compares the ALU `result`/`zero` against the expected values. It accumulates an error count and reports pass/fail, which lets the ALU be checked on the board without a simulator.

---
 rtl/alu_test_pkg.sv | 28 ++
 rtl/alu_vec_checker.sv | 14 +
 rtl/alu_vector_player.sv | 137 +++++++++++++
 tb/tb_alu_vector_player.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_test_pkg.sv
// Shared constants and types for the ALU self-test vector player.
// A vector word is {aluop, a, b, exp_result}, most significant field first.
package alu_test_pkg;

    localparam int VEC_W = 100;

    localparam int OP_MSB  = 99;
    localparam int OP_LSB  = 96;
    localparam int A_MSB   = 95;
    localparam int A_LSB   = 64;
    localparam int B_MSB   = 63;
    localparam int B_LSB   = 32;
    localparam int EXP_MSB = 31;
    localparam int EXP_LSB = 0;

    localparam int               ERR_W   = 11;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_vec_checker.sv
// Compares the ALU outputs against the expected result and its derived zero flag.
// Uses case inequality so that any X/Z on the ALU outputs is reported as a mismatch.
module alu_vec_checker (
    input  logic [31:0] exp_result,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        exp_zero,
    output logic        mismatch
);

    assign exp_zero = ~|exp_result;
    assign mismatch = (alu_result !== exp_result) || (alu_zero !== exp_zero);

endmodule

// File: rtl/alu_vector_player.sv
// Self-test sequencer: plays vectors from a synchronous ROM through the ALU
// and accumulates mismatches into a saturating error count.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for start after reset
//   ST_FETCH  | vec_addr = idx, covering the one-cycle ROM latency
//   ST_LOAD   | capture ROM word into ALU drive regs, load settle timer
//   ST_SETTLE | down-count settle timer, leave on terminal count
//   ST_CHECK  | compare ALU outputs, record mismatch, advance or finish
//   ST_DONE   | results held until the next start
module alu_vector_player
    import alu_test_pkg::*;
#(
    parameter int NUM_VECTORS   = 12,
    parameter int ADDR_W        = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [3:0]        alu_aluop,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [31:0]       alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_idx
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VECTORS - 1);

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [CNT_W-1:0]   settle_cnt;
    logic [31:0]        exp_result;
    logic               exp_zero_unused;
    logic               mismatch;
    logic [ERR_W-1:0]   err_nxt;

    assign vec_addr = idx;

    alu_vec_checker u_checker (
        .exp_result (exp_result),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .exp_zero   (exp_zero_unused),
        .mismatch   (mismatch)
    );

    // Saturating increment; pass must see the count including the final vector.
    always_comb begin
        err_nxt = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX)) begin
            err_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            exp_result <= '0;
            alu_aluop  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            fail_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        idx      <= '0;
                        err_cnt  <= '0;
                        fail_idx <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    alu_aluop  <= vec_data[OP_MSB:OP_LSB];
                    alu_a      <= vec_data[A_MSB:A_LSB];
                    alu_b      <= vec_data[B_MSB:B_LSB];
                    exp_result <= vec_data[EXP_MSB:EXP_LSB];
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_cnt <= err_nxt;
                    if (mismatch) begin
                        fail_valid <= 1'b1;
                        fail_idx   <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vector_player.sv
// Directed bench for alu_vector_player: behavioural ROM plus an ALU model with
// fault injection for wrong result, wrong zero flag and X result.
module tb_alu_vector_player;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   vec_addr;
    logic [99:0]  vec_data;
    logic [3:0]   alu_aluop;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [31:0]  alu_result;
    logic         alu_zero;
    logic         busy;
    logic         done;
    logic         pass;
    logic [10:0]  err_cnt;
    logic         fail_valid;
    logic [6:0]   fail_idx;

    logic [99:0]  rom [128];
    logic [31:0]  model_r;
    bit           x_vec0 = 1'b0;
    bit           zero_bad1 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_vector_player dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .vec_addr   (vec_addr),
        .vec_data   (vec_data),
        .alu_aluop  (alu_aluop),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .fail_idx   (fail_idx)
    );

    always @(posedge clk) vec_data <= rom[vec_addr];

    always_comb begin
        case (alu_aluop)
            4'd0:    model_r = alu_a + alu_b;
            4'd1:    model_r = alu_a - alu_b;
            4'd2:    model_r = alu_a & alu_b;
            4'd3:    model_r = alu_a | alu_b;
            4'd4:    model_r = alu_a ^ alu_b;
            default: model_r = 32'h0;
        endcase
        alu_result = model_r;
        alu_zero   = ~|model_r;
        if (zero_bad1 && vec_addr == 7'd1) alu_zero = 1'b0;
        if (x_vec0 && vec_addr == 7'd0) begin
            alu_result = 32'bx;
            alu_zero   = 1'bx;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-computed vectors; vector 4 optionally carries a wrong expected value (9 for 5+3).
    task automatic build_rom(input bit bad4);
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0]  = {4'd0, 32'h00000005, 32'h00000003, 32'h00000008};
        rom[1]  = {4'd1, 32'h0000000A, 32'h0000000A, 32'h00000000};
        rom[2]  = {4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        rom[3]  = {4'd3, 32'h0000FF00, 32'h00FF0000, 32'h00FFFF00};
        rom[4]  = {4'd0, 32'h00000005, 32'h00000003, bad4 ? 32'h00000009 : 32'h00000008};
        rom[5]  = {4'd4, 32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987};
        rom[6]  = {4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        rom[7]  = {4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE};
        rom[8]  = {4'd2, 32'h12345678, 32'h00000000, 32'h00000000};
        rom[9]  = {4'd3, 32'h00000001, 32'h00000002, 32'h00000003};
        rom[10] = {4'd4, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF};
        rom[11] = {4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    endtask

    // Pulses start, then counts edges until done, optionally pulsing start at cycles 10 and 30.
    task automatic run_and_wait(input bit inject, output int cyc, output int nfail,
                                output logic busy0, output logic [10:0] err0);
        nfail = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        busy0 = busy;
        err0  = err_cnt;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (fail_valid) nfail++;
            start = inject && (cyc == 10 || cyc == 30);
        end
        start = 1'b0;
    endtask

    int           cyc;
    int           nfail;
    logic         busy0;
    logic [10:0]  err0;

    initial begin
        build_rom(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fail_valid", fail_valid, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_fail_idx", fail_idx, 0);
        check_eq("rst_vec_addr", vec_addr, 0);
        check_eq("rst_alu_a", alu_a, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // clean run
        run_and_wait(1'b0, cyc, nfail, busy0, err0);
        check_eq("clean_busy_rise", busy0, 1);
        check_eq("clean_cycles", cyc, 60);
        check_eq("clean_pass", pass, 1);
        check_eq("clean_err_cnt", err_cnt, 0);
        check_eq("clean_fail_pulses", nfail, 0);
        check_eq("clean_busy_fall", busy, 0);

        // restart from DONE with a wrong expected value on vector 4
        build_rom(1'b1);
        run_and_wait(1'b0, cyc, nfail, busy0, err0);
        check_eq("bad4_cycles", cyc, 60);
        check_eq("bad4_fail_pulses", nfail, 1);
        check_eq("bad4_fail_idx", fail_idx, 4);
        check_eq("bad4_err_cnt", err_cnt, 1);
        check_eq("bad4_pass", pass, 0);

        // clean run with start pulses mid-run that must be ignored
        build_rom(1'b0);
        run_and_wait(1'b1, cyc, nfail, busy0, err0);
        check_eq("restart_err_cleared", err0, 0);
        check_eq("ignored_start_cycles", cyc, 60);
        check_eq("ignored_start_pass", pass, 1);
        check_eq("ignored_start_err", err_cnt, 0);

        // zero flag wrong on vector 1 (result itself correct)
        zero_bad1 = 1'b1;
        run_and_wait(1'b0, cyc, nfail, busy0, err0);
        zero_bad1 = 1'b0;
        check_eq("zero_err_cnt", err_cnt, 1);
        check_eq("zero_fail_idx", fail_idx, 1);
        check_eq("zero_pass", pass, 0);
        check_eq("zero_fail_pulses", nfail, 1);

        // X result on vector 0
        x_vec0 = 1'b1;
        run_and_wait(1'b0, cyc, nfail, busy0, err0);
        check_eq("x_err_cnt", err_cnt, 1);
        check_eq("x_fail_idx", fail_idx, 0);
        check_eq("x_pass", pass, 0);

        // reset asserted 25 cycles into a run with a recorded error
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_eq("mid_err_before_rst", err_cnt, 1);
        check_eq("mid_busy_before_rst", busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_err_cnt", err_cnt, 0);
        check_eq("mid_rst_vec_addr", vec_addr, 0);
        check_eq("mid_rst_alu_a", alu_a, 0);
        check_eq("mid_rst_alu_aluop", alu_aluop, 0);
        x_vec0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_vec_addr", vec_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
